// File: rtl/r5fp_sqrt_sched.sv
// Round-robin scheduler sharing one sequential FP sqrt unit among N_REQ requesters.
// Define R5FP_SQRT_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog (qNaN + timeout_err).
module r5fp_sqrt_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SIG_W   = 23,
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  logic [N_REQ*(SIG_W+EXP_W+1)-1:0]       req_a,
  input  logic [N_REQ*3-1:0]                     req_rnd,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rsp_id,
  output logic [SIG_W+EXP_W:0]                   rsp_z,
  output logic [7:0]                             rsp_status,
  output logic                                   sq_strobe,
  output logic [SIG_W+EXP_W:0]                   sq_a,
  output logic [2:0]                             sq_rnd,
  input  logic                                   sq_ready,
  input  logic                                   sq_complete,
  input  logic [SIG_W+EXP_W:0]                   sq_z,
  input  logic [7:0]                             sq_status,
  output logic                                   busy,
  output logic                                   timeout_err
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned FW   = SIG_W + EXP_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [FW-1:0]     a_q, a_d;
  logic [2:0]        rnd_q, rnd_d;
  logic [FW-1:0]     z_q, z_d;
  logic [7:0]        status_q, status_d;

  logic              found;
  logic [ID_W-1:0]   pick;
  logic              grant;
  logic [FW-1:0]     a_sel;
  logic [2:0]        rnd_sel;
  int unsigned       sum;

  // Rotating priority: first valid requester after the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      sum = 32'(last_q) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      if (!found && req_valid[ID_W'(sum)]) begin
        found = 1'b1;
        pick  = ID_W'(sum);
      end
    end
  end

  always_comb begin
    a_sel   = '0;
    rnd_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick == ID_W'(i)) begin
        a_sel   = req_a[i*FW +: FW];
        rnd_sel = req_rnd[i*3 +: 3];
      end
    end
  end

  assign grant     = (state_q == StIdle) && found && sq_ready && !reset;
  assign req_ready = grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << pick) : '0;

`ifdef R5FP_SQRT_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W       = $clog2(TIMEOUT + 1);
  localparam int unsigned ZInvalidBit = 2;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    a_d      = a_q;
    rnd_d    = rnd_q;
    z_d      = z_q;
    status_d = status_q;
`ifdef R5FP_SQRT_SCHED_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          id_d    = pick;
          last_d  = pick;
          a_d     = a_sel;
          rnd_d   = rnd_sel;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef R5FP_SQRT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // A completion in the expiry cycle still delivers the real result.
        if (sq_complete) begin
          z_d      = sq_z;
          status_d = sq_status;
          state_d  = StResp;
        end
`ifdef R5FP_SQRT_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          z_d                   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
          status_d              = '0;
          status_d[ZInvalidBit] = 1'b1;
          terr_d                = 1'b1;
          state_d               = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= ID_W'(N_REQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      rnd_q    <= '0;
      z_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      a_q      <= a_d;
      rnd_q    <= rnd_d;
      z_q      <= z_d;
      status_q <= status_d;
    end
  end

`ifdef R5FP_SQRT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign sq_strobe  = (state_q == StIssue);
  assign sq_a       = a_q;
  assign sq_rnd     = rnd_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = id_q;
  assign rsp_z      = z_q;
  assign rsp_status = status_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_r5fp_sqrt_sched.sv
// Bench for r5fp_sqrt_sched: stub sqrt unit, arbitration/scoreboard model, directed + random steps.
module tb_r5fp_sqrt_sched;

  localparam int N  = 4;
  localparam int FW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  req_a;
  logic [11:0]   req_rnd;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_z;
  logic [7:0]    rsp_status;
  logic          sq_strobe;
  logic [31:0]   sq_a;
  logic [2:0]    sq_rnd;
  logic          sq_ready;
  logic          sq_complete;
  logic [31:0]   sq_z;
  logic [7:0]    sq_status;
  logic          busy;
  logic          timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int last_g;
  int strobe_cnt = 0;
  int terr_cnt   = 0;

  logic        stub_busy;
  logic        hang;
  logic        block;
  int          stub_lat;
  int          stub_cnt;
  logic [31:0] stub_a;

  r5fp_sqrt_sched #(.N_REQ(N), .SIG_W(23), .EXP_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_rnd(req_rnd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_status(rsp_status), .sq_strobe(sq_strobe), .sq_a(sq_a), .sq_rnd(sq_rnd),
    .sq_ready(sq_ready), .sq_complete(sq_complete), .sq_z(sq_z), .sq_status(sq_status),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference results the stub returns: {status, z}.
  function automatic logic [39:0] model_sqrt(input logic [31:0] a);
    case (a)
      32'h4080_0000: return {8'h00, 32'h4000_0000};
      32'h4000_0000: return {8'h20, 32'h3FB5_04F3};
      32'h0000_0000: return {8'h01, 32'h0000_0000};
      default:       return {a[31:24], a ^ 32'h5A5A_5A5A};
    endcase
  endfunction

  assign sq_ready = !stub_busy && !block;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_busy   <= 1'b0;
      sq_complete <= 1'b0;
      sq_z        <= '0;
      sq_status   <= '0;
      stub_cnt    <= 0;
      stub_a      <= '0;
    end else begin
      sq_complete <= 1'b0;
      sq_z        <= $urandom;
      sq_status   <= 8'($urandom);
      if (sq_strobe && !stub_busy) begin
        stub_busy <= 1'b1;
        stub_a    <= sq_a;
        stub_cnt  <= stub_lat;
      end else if (stub_busy && !hang) begin
        if (stub_cnt == 0) begin
          {sq_status, sq_z} <= model_sqrt(stub_a);
          sq_complete       <= 1'b1;
          stub_busy         <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (sq_strobe)   strobe_cnt <= strobe_cnt + 1;
    if (timeout_err) terr_cnt   <= terr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_grant(input logic [3:0] mask);
    int g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_g + k) % N;
      if (g < 0 && mask[c]) g = c;
    end
    return g;
  endfunction

  // One full transaction from the currently driven request vector.
  task automatic serve(input int hold);
    int          g;
    int          waited;
    int          s0;
    logic [31:0] ea;
    logic [2:0]  er;
    logic [39:0] m;
    #1;
    g = next_grant(req_valid);
    waited = 0;
    while (req_ready == 4'b0 && waited < 20) begin
      tick();
      waited++;
    end
    chk("grant", {60'b0, req_ready}, {60'b0, 4'(4'b1 << g)});
    if (req_ready == 4'b0) return;
    ea     = req_a[g*FW +: FW];
    er     = req_rnd[g*3 +: 3];
    last_g = g;
    s0     = strobe_cnt;
    tick();
    chk("issue", {sq_strobe, req_ready, busy, sq_rnd, sq_a}, {1'b1, 4'b0, 1'b1, er, ea});
    waited = 0;
    while (!rsp_valid && waited < 60) begin
      tick();
      waited++;
    end
    m = model_sqrt(ea);
    chk("rsp", {rsp_valid, rsp_id, rsp_status, rsp_z}, {1'b1, 2'(g), m});
    chk("one strobe", 64'(strobe_cnt - s0), 64'd1);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        tick();
        chk("hold", {rsp_valid, rsp_id, rsp_status, rsp_z, req_ready, sq_strobe},
            {1'b1, 2'(g), m, 4'b0, 1'b0});
      end
      rsp_ready = 1'b1;
    end
    tick();
    chk("rsp drop", {63'b0, rsp_valid}, 64'd0);
    chk("no extra strobe", 64'(strobe_cnt - s0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ctl"}, {req_ready, sq_strobe, rsp_valid, busy, timeout_err, rsp_id, rsp_status,
                        sq_rnd}, 64'd0);
    chk({tag, " data"}, {rsp_z, sq_a}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int t0;
    int g;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_rnd   = '0;
    rsp_ready = 1'b1;
    hang      = 1'b0;
    block     = 1'b0;
    stub_lat  = 2;
    last_g    = N - 1;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // 4.0 from requester 0
    req_a[0*FW +: FW] = 32'h4080_0000;
    req_rnd[0 +: 3]   = 3'd0;
    req_valid         = 4'b0001;
    serve(0);
    req_valid = '0;

    // 2.0 from requester 2, inexact result, short hold
    stub_lat          = 4;
    req_a[2*FW +: FW] = 32'h4000_0000;
    req_rnd[6 +: 3]   = 3'd0;
    req_valid         = 4'b0100;
    serve(3);
    req_valid = '0;

    // No grant while the sqrt unit is not ready
    block     = 1'b1;
    req_valid = 4'b1111;
    repeat (3) begin
      tick();
      chk("no grant busy unit", {req_ready, busy}, 5'b0);
    end
    req_valid = '0;
    block     = 1'b0;

    // Round robin with all requesters held valid, requester 1 sends zero
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    last_g = N - 1;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_a[1*FW +: FW] = 32'h0;
      req_rnd  = 12'($urandom);
      stub_lat = $urandom_range(0, 5);
      serve(0);
    end
    req_valid = '0;

    // Random request masks, operands, latencies and back-pressure
    for (int i = 0; i < 24; i++) begin
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_rnd   = 12'($urandom);
      req_valid = 4'($urandom_range(1, 15));
      stub_lat  = $urandom_range(0, 5);
      serve($urandom_range(0, 3));
    end
    req_valid = '0;

    // Ten-cycle response stall
    req_a[3*FW +: FW] = $urandom;
    req_valid = 4'b1000;
    serve(10);
    req_valid = '0;

    // Reset asserted while waiting for the sqrt unit
    hang = 1'b1;
    req_valid = 4'b0001;
    req_a[0*FW +: FW] = $urandom;
    serve_partial: begin
      #1;
      n = 0;
      while (req_ready == 4'b0 && n < 20) begin
        tick();
        n++;
      end
      tick();
      tick();
      chk("in wait", {62'b0, busy, rsp_valid}, 64'd2);
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("reset mid-op");
    tick();
    reset     = 1'b0;
    hang      = 1'b0;
    last_g    = N - 1;
    req_valid = 4'b0010;
    req_a[1*FW +: FW] = $urandom;
    serve(0);
    req_valid = '0;

    // Stub never completes
    hang = 1'b1;
    req_a[2*FW +: FW] = $urandom;
    req_valid = 4'b0100;
    #1;
    g = next_grant(req_valid);
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("hang grant", {60'b0, req_ready}, {60'b0, 4'(4'b1 << g)});
    last_g = g;
    tick();
    req_valid = '0;
    t0 = terr_cnt;
    n  = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
`ifdef R5FP_SQRT_SCHED_TIMEOUT_EN
    chk("timeout latency", 64'(n), 64'(TO + 1));
    chk("timeout rsp", {timeout_err, rsp_id, rsp_status, rsp_z},
        {1'b1, 2'(g), 8'h04, 32'h7FC0_0000});
    tick();
    tick();
    chk("timeout pulses", 64'(terr_cnt - t0), 64'd1);
    chk("timeout done", {62'b0, busy, rsp_valid}, 64'd0);
`else
    chk("no timeout", {61'b0, rsp_valid, busy, timeout_err}, 64'd2);
    chk("no timeout pulses", 64'(terr_cnt - t0), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
